// File: rtl/instr_trace_buffer_pkg.sv
// Shared widths and field layout for commit-trace entries.
// An entry is packed {seq, pc, instr} with instr in the least significant bits.
package trace_pkg;
  localparam int SEQ_W     = 32;
  localparam int PC_W      = 32;
  localparam int INSTR_W   = 32;
  localparam int ENTRY_W   = SEQ_W + PC_W + INSTR_W;
  localparam int INSTR_LSB = 0;
  localparam int PC_LSB    = INSTR_W;
  localparam int SEQ_LSB   = INSTR_W + PC_W;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [SEQ_W-1:0] seq,
                                                    input logic [PC_W-1:0] pc,
                                                    input logic [INSTR_W-1:0] instr);
    return {seq, pc, instr};
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// Show-ahead register-array FIFO with synchronous clear.
// The head is read combinationally and reads as zero while empty.
module trace_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ENTRY_W = 96
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic [AW:0]        count,
  output logic               full,
  output logic               empty
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic               pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/instr_trace_buffer.sv
// Commit-trace capture: edge-detects instr_change, tags {pc, ir} with a sequence
// number and queues it for a valid/ready reader; drops are counted when full.
module instr_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int OVF_W = 16
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               instr_change,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] ir_in,
  input  logic               clear,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [SEQ_W-1:0]   rd_seq,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [AW:0]        count,
  output logic               full,
  output logic               empty,
  output logic [OVF_W-1:0]   overflow_cnt
);
  logic               chg_q, commit, pop, push, drop;
  logic [SEQ_W-1:0]   seq;
  logic [ENTRY_W-1:0] head;

  assign commit   = instr_change & ~chg_q;
  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign push     = commit & (~full | pop);
  assign drop     = commit & full & ~pop;

  // chg_q keeps tracking through clear so a held level does not re-commit
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) chg_q <= 1'b0;
    else        chg_q <= instr_change;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      seq          <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      seq          <= '0;
      overflow_cnt <= '0;
    end else begin
      if (commit) seq <= seq + 1'b1;
      if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .AW(AW), .ENTRY_W(ENTRY_W)) u_fifo (
    .clk   (clk_in),
    .rst_n (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (pack_entry(seq, pc_in, ir_in)),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_seq   = head[SEQ_LSB   +: SEQ_W];
  assign rd_pc    = head[PC_LSB    +: PC_W];
  assign rd_instr = head[INSTR_LSB +: INSTR_W];
endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed plus randomized bench for instr_trace_buffer against a queue-based model.
module tb_instr_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk_in = 1'b0, reset = 1'b0;
  logic        instr_change = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic [31:0] pc_in = '0, ir_in = '0;
  logic        rd_valid, full, empty;
  logic [31:0] rd_seq, rd_pc, rd_instr;
  logic [4:0]  count;
  logic [15:0] overflow_cnt;

  instr_trace_buffer #(.DEPTH(DEPTH), .AW(4), .OVF_W(16)) dut (
    .clk_in(clk_in), .reset(reset), .instr_change(instr_change),
    .pc_in(pc_in), .ir_in(ir_in), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_seq(rd_seq), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] seq, pc, instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_seq;
  int          m_ovf;
  logic        m_chg;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = '0;
    m_ovf = 0;
    m_chg = 1'b0;
  endtask

  task automatic cmp_all(input string tag);
    bit ne;
    ne = (q.size() > 0);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(ne));
    chk({tag, ".seq"},   rd_seq,   ne ? q[0].seq   : 32'h0);
    chk({tag, ".pc"},    rd_pc,    ne ? q[0].pc    : 32'h0);
    chk({tag, ".instr"}, rd_instr, ne ? q[0].instr : 32'h0);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(overflow_cnt), 32'(m_ovf));
  endtask

  // Apply one clock edge to the model using current inputs, then compare.
  task automatic tick(input string tag = "cyc");
    bit cm, pp;
    cm = instr_change && !m_chg;
    pp = rd_ready && (q.size() > 0);
    if (clear) begin
      q.delete();
      m_seq = '0;
      m_ovf = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (cm) begin
        if (q.size() < DEPTH) q.push_back('{m_seq, pc_in, ir_in});
        else if (m_ovf < 65535) m_ovf++;
        m_seq = m_seq + 1;
      end
    end
    m_chg = instr_change;
    @(posedge clk_in);
    #1;
    cmp_all(tag);
  endtask

  task automatic pulse(input logic [31:0] pc, input logic [31:0] ir, input int hi, input int lo);
    instr_change = 1'b1; pc_in = pc; ir_in = ir;
    repeat (hi) tick();
    instr_change = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick("clr"); clear = 1'b0;
  endtask

  initial begin
    int rate;
    model_reset();
    #2 cmp_all("reset");
    @(posedge clk_in); #1;
    reset = 1'b1;

    // 1: three pulses, then drain in order
    for (int i = 0; i < 3; i++) pulse(32'h0040_0000 + 32'(4*i), 32'h2001_0001 + 32'(i), 2, 2);
    chk("t1.count", 32'(count), 32'd3);
    chk("t1.seq0", rd_seq, 32'd0);
    chk("t1.pc0", rd_pc, 32'h0040_0000);
    chk("t1.ir0", rd_instr, 32'h2001_0001);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1.order", rd_seq, 32'(i));
      tick("t1");
    end
    rd_ready = 1'b0;
    chk("t1.empty", 32'(empty), 32'd1);

    // 2: level held high commits once
    pulse(32'h1000, 32'h1111, 10, 1);
    chk("t2.count", 32'(count), 32'd1);
    chk("t2.seq", rd_seq, 32'd3);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // 3: 20 commits into a 16-deep FIFO
    do_clear();
    for (int i = 0; i < 20; i++) pulse(32'h2000 + 32'(i), 32'h3000 + 32'(i), 1, 1);
    chk("t3.full", 32'(full), 32'd1);
    chk("t3.count", 32'(count), 32'd16);
    chk("t3.ovf", 32'(overflow_cnt), 32'd4);
    chk("t3.head", rd_seq, 32'd0);

    // 4: commit and pop on the same edge while full
    instr_change = 1'b1; rd_ready = 1'b1; pc_in = 32'hABCD; ir_in = 32'h1234;
    tick("t4");
    instr_change = 1'b0; rd_ready = 1'b0;
    chk("t4.count", 32'(count), 32'd16);
    chk("t4.ovf", 32'(overflow_cnt), 32'd4);
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t3.drain", rd_seq, 32'(i));
      tick("t4d");
    end
    chk("t4.tail", rd_seq, 32'd20);
    tick(); rd_ready = 1'b0;

    // 5: clear together with a commit edge
    for (int i = 0; i < 5; i++) pulse(32'h4000 + 32'(i), 32'h5000, 1, 1);
    instr_change = 1'b1; clear = 1'b1;
    tick("t5");
    clear = 1'b0;
    chk("t5.count", 32'(count), 32'd0);
    chk("t5.ovf", 32'(overflow_cnt), 32'd0);
    tick(); instr_change = 1'b0; tick();
    chk("t5.noretrig", 32'(count), 32'd0);
    pulse(32'h6000, 32'h6001, 1, 1);
    chk("t5.seq", rd_seq, 32'd0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 6; i++) pulse(32'h7000 + 32'(i), 32'h7100, 1, 1);
    chk("t6.pre", 32'(count), 32'd7);
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("t6.valid", 32'(rd_valid), 32'd0);
    chk("t6.count", 32'(count), 32'd0);
    chk("t6.ovf", 32'(overflow_cnt), 32'd0);
    @(posedge clk_in); #1;
    reset = 1'b1;
    pulse(32'h8000, 32'h8001, 1, 1);
    chk("t6.seq", rd_seq, 32'd0);

    // randomized traffic, alternating slow and fast readers
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 250) % 2 == 0) ? 15 : 85;
      instr_change = 1'($urandom_range(0, 1));
      pc_in        = $urandom;
      ir_in        = $urandom;
      rd_ready     = ($urandom_range(0, 99) < rate);
      clear        = ($urandom_range(0, 199) == 0);
      tick("rnd");
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
